pid_mc: RTL
===========

Name: pid_mc

Overview:
- Parametrised, multi-channel, time-multiplexed PID controller; next generation of the single-channel 16-bit PID core.
- One shared arithmetic pipeline serves CH independent loops. Each loop has its own gains, previous error and integrator.
- Adds valid/channel tagging, per-channel integrator clamp (anti-windup), fixed-point output scaling and saturation instead of zeroing on overflow.
- Sits between the sensor-sample sequencer (SV/PV per channel) and the actuator drivers.

Parameters:
- W, 16, signed width of SV, PV, gains and MV
- CH, 4, number of channels (>=1); CHW = max(1, clog2(CH)) is a localparam
- IW, 24, signed integrator width (IW > W+1)
- INT_LIM, 1048575, integrator magnitude limit; must be < 2^(IW-1)
- FRAC, 8, gain fractional bits; the sum is arithmetic-shifted right by FRAC

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  sample strobe
- in_ch  in  CHW  sample channel
- sv  in  W  set value, signed
- pv  in  W  present value, signed
- cfg_we  in  1  config write strobe
- cfg_ch  in  CHW  config channel
- cfg_sel  in  2  0=Kp, 1=Ki, 2=Kd, 3=clear channel state
- cfg_data  in  W  gain value, signed Q(W-FRAC).FRAC
- out_valid  out  1  result strobe
- out_ch  out  CHW  result channel
- mv  out  W  manipulated value, signed, saturated
- out_sat  out  1  mv was saturated
- out_iclamp  out  1  integrator was clamped for this sample

Behaviour:
- Reset (async, rst=0): all outputs 0. Gains, prev_e[], integ[] and all pipeline valids clear immediately. Reset mid-stream drops in-flight samples with no partial outputs.
- Streaming, no backpressure: in_valid may be high every cycle, any channel order.
- Latency is fixed: a sample accepted at edge k produces out_valid=1 in the cycle after edge k+3 (4 register stages R1..R4).
- in_ch >= CH: sample dropped. No state update, no output.
- R1 (state stage), all state updates for a sample complete in this stage, so back-to-back same-channel samples need no forwarding:
  - e = sv - pv, W+1 bits, exact.
  - de = e - prev_e[ch], W+2 bits.
  - s = integ[ch] + e. If s > INT_LIM then ni = INT_LIM, iclamp = 1; if s < -INT_LIM then ni = -INT_LIM, iclamp = 1; otherwise ni = s.
  - Write prev_e[ch] = e and integ[ch] = ni.
  - Register e, de, ni, ch, iclamp, valid.
- R2: pp = Kp*e, pi = Ki*ni, pd = Kd*de, using the channel's gains sampled in R1; full-precision signed products.
- R3: acc = pp + pi + pd in ACC_W = W+IW+2 bits (cannot overflow), then arithmetic shift right by FRAC (floor).
- R4: saturate to [-2^(W-1), 2^(W-1)-1]. out_sat = 1 when clipped. Register mv, out_ch, out_iclamp, out_valid.
- Config:
  - A gain write at edge k applies to samples entering R1 at edge k+1 or later.
  - cfg_sel=3 zeroes prev_e and integ of cfg_ch and leaves gains unchanged.
  - A clear in the same cycle as a sample on the same channel: the sample computes with the old state, and clear wins for the state write (state ends at 0).
  - cfg_ch >= CH: write ignored.
- out_valid is low on every cycle with no result; mv holds its last value.

Decomposition:
- pid_mc_pkg holds: cfg_sel encodings (CFG_KP, CFG_KI, CFG_KD, CFG_CLR), the saturate-to-W function, and the symmetric clamp function.
- Sub-module pid_mc_state: per-channel register file for gains, prev_e and integ, with the clear-priority write logic and async reset.
- The pipeline itself stays in pid_mc.

Test Plan:
(All at W=16, CH=4, IW=24, FRAC=8, INT_LIM=1048575.)
- ch0 Kp=256, Ki=Kd=0; sv=1000, pv=400 accepted at edge k -> out_valid at k+4, out_ch=0, mv=600, out_sat=0.
- ch1 Ki=256 only; three samples with e=10 -> mv=10, 20, 30.
- ch2 Kd=256 only; samples e=100 then e=150 -> mv=100 then 50. Then cfg clear on ch2 and e=150 again -> mv=150.
- ch0 and ch1 alternating every cycle for 8 samples with different gains -> each output matches a per-channel reference model; no crosstalk; out_valid continuous.
- ch3 Kp=0x7FFF; sv=32767, pv=-32768 -> mv=32767, out_sat=1. Swap sv and pv -> mv=-32768, out_sat=1.
- ch0 Ki=1 only, e=32767 repeated:
  - Samples 1-32: integrator unclamped, out_iclamp=0.
  - Sample 33 onward: out_iclamp=1, integ=1048575, mv=4095.
  - Assert rst mid-stream -> out_valid=0 immediately, and the next sample after release starts from integ=0.

Source files
------------

// File: rtl/pid_mc_pkg.sv
// Shared definitions for the multi-channel PID controller: config selectors
// and the saturation / symmetric clamp helpers.
package pid_mc_pkg;

  typedef enum logic [1:0] {
    CFG_KP  = 2'd0,
    CFG_KI  = 2'd1,
    CFG_KD  = 2'd2,
    CFG_CLR = 2'd3
  } cfg_sel_e;

  // Saturate x to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r  = x;
    if (x > hi)      r = hi;
    else if (x < lo) r = lo;
    return r;
  endfunction

  // Clamp x to [-lim, lim].
  function automatic logic signed [63:0] clamp_sym(input logic signed [63:0] x,
                                                   input logic signed [63:0] lim);
    logic signed [63:0] r;
    r = x;
    if (x > lim)       r = lim;
    else if (x < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/pid_mc_state.sv
// Per-channel register file: gains, previous error and integrator, with a
// config-clear that takes priority over the pipeline's state write.
module pid_mc_state
  import pid_mc_pkg::*;
#(
  parameter int W   = 16,
  parameter int CH  = 4,
  parameter int CHW = 2,
  parameter int IW  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [1:0]           cfg_sel,
  input  logic signed [W-1:0]  cfg_data,
  input  logic [CHW-1:0]       rd_ch,
  input  logic                 st_we,
  input  logic [CHW-1:0]       st_ch,
  input  logic signed [W:0]    st_e,
  input  logic signed [IW-1:0] st_i,
  output logic signed [W-1:0]  kp,
  output logic signed [W-1:0]  ki,
  output logic signed [W-1:0]  kd,
  output logic signed [W:0]    prev_e,
  output logic signed [IW-1:0] integ
);

  logic signed [W-1:0]  kp_q [CH];
  logic signed [W-1:0]  ki_q [CH];
  logic signed [W-1:0]  kd_q [CH];
  logic signed [W:0]    pe_q [CH];
  logic signed [IW-1:0] ig_q [CH];
  logic [CHW-1:0]       rd_idx;

  always_comb begin
    rd_idx = '0;
    if ({{(32-CHW){1'b0}}, rd_ch} < 32'(CH)) rd_idx = rd_ch;
  end

  assign kp     = kp_q[rd_idx];
  assign ki     = ki_q[rd_idx];
  assign kd     = kd_q[rd_idx];
  assign prev_e = pe_q[rd_idx];
  assign integ  = ig_q[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        kp_q[i] <= '0;
        ki_q[i] <= '0;
        kd_q[i] <= '0;
        pe_q[i] <= '0;
        ig_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (st_we && st_ch == CHW'(i)) begin
          pe_q[i] <= st_e;
          ig_q[i] <= st_i;
        end
        // The clear is issued after the state write so it wins on a collision.
        if (cfg_we && cfg_ch == CHW'(i)) begin
          case (cfg_sel_e'(cfg_sel))
            CFG_KP:  kp_q[i] <= cfg_data;
            CFG_KI:  ki_q[i] <= cfg_data;
            CFG_KD:  kd_q[i] <= cfg_data;
            CFG_CLR: begin
              pe_q[i] <= '0;
              ig_q[i] <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/pid_mc.sv
// Time-multiplexed multi-channel PID: state update in R1, products in R2,
// sum and scale in R3, saturation in R4.
module pid_mc
  import pid_mc_pkg::*;
#(
  parameter int W       = 16,
  parameter int CH      = 4,
  parameter int IW      = 24,
  parameter int INT_LIM = 1048575,
  parameter int FRAC    = 8,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CHW-1:0]      in_ch,
  input  logic signed [W-1:0] sv,
  input  logic signed [W-1:0] pv,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic signed [W-1:0] cfg_data,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic signed [W-1:0] mv,
  output logic                out_sat,
  output logic                out_iclamp
);

  localparam int ACC_W = W + IW + 2;
  localparam int PP_W  = 2 * W + 1;
  localparam int PI_W  = W + IW;
  localparam int PD_W  = 2 * W + 2;

  logic                 in_ok;
  logic signed [W-1:0]  g_kp, g_ki, g_kd;
  logic signed [W:0]    st_pe;
  logic signed [IW-1:0] st_ig;

  logic signed [W:0]    e_c;
  logic signed [W+1:0]  de_c;
  logic signed [IW:0]   s_c;
  logic signed [63:0]   s64, cl64;
  logic signed [IW-1:0] ni_c;
  logic                 ic_c;

  assign in_ok = in_valid && ({{(32-CHW){1'b0}}, in_ch} < 32'(CH));

  pid_mc_state #(.W(W), .CH(CH), .CHW(CHW), .IW(IW)) u_state (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .rd_ch(in_ch),
    .st_we(in_ok), .st_ch(in_ch), .st_e(e_c), .st_i(ni_c),
    .kp(g_kp), .ki(g_ki), .kd(g_kd), .prev_e(st_pe), .integ(st_ig)
  );

  always_comb begin
    e_c  = {sv[W-1], sv} - {pv[W-1], pv};
    de_c = {e_c[W], e_c} - {st_pe[W], st_pe};
    s_c  = {st_ig[IW-1], st_ig} + {{(IW-W){e_c[W]}}, e_c};
    s64  = {{(63-IW){s_c[IW]}}, s_c};
    cl64 = clamp_sym(s64, 64'(INT_LIM));
    ni_c = cl64[IW-1:0];
    ic_c = (cl64 != s64);
  end

  logic                 r1_v, r1_ic;
  logic [CHW-1:0]       r1_ch;
  logic signed [W:0]    r1_e;
  logic signed [W+1:0]  r1_de;
  logic signed [IW-1:0] r1_ni;
  logic signed [W-1:0]  r1_kp, r1_ki, r1_kd;

  logic                 r2_v, r2_ic;
  logic [CHW-1:0]       r2_ch;
  logic signed [PP_W-1:0] r2_pp;
  logic signed [PI_W-1:0] r2_pi;
  logic signed [PD_W-1:0] r2_pd;

  logic                 r3_v, r3_ic;
  logic [CHW-1:0]       r3_ch;
  logic signed [ACC_W-1:0] r3_y;

  // Operands are sign-extended to the product width; the low bits of the
  // unsigned product are then the exact signed result.
  logic signed [PP_W-1:0]  pp_c;
  logic signed [PI_W-1:0]  pi_c;
  logic signed [PD_W-1:0]  pd_c;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [63:0]      y64, sat64;

  always_comb begin
    pp_c  = {{(W+1){r1_kp[W-1]}}, r1_kp} * {{W{r1_e[W]}}, r1_e};
    pi_c  = {{IW{r1_ki[W-1]}}, r1_ki} * {{W{r1_ni[IW-1]}}, r1_ni};
    pd_c  = {{(W+2){r1_kd[W-1]}}, r1_kd} * {{W{r1_de[W+1]}}, r1_de};
    acc_c = {{(ACC_W-PP_W){r2_pp[PP_W-1]}}, r2_pp}
          + {{(ACC_W-PI_W){r2_pi[PI_W-1]}}, r2_pi}
          + {{(ACC_W-PD_W){r2_pd[PD_W-1]}}, r2_pd};
    y64   = {{(64-ACC_W){r3_y[ACC_W-1]}}, r3_y};
    sat64 = sat_w(y64, W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_v <= 1'b0; r1_ic <= 1'b0; r1_ch <= '0;
      r1_e <= '0; r1_de <= '0; r1_ni <= '0;
      r1_kp <= '0; r1_ki <= '0; r1_kd <= '0;
      r2_v <= 1'b0; r2_ic <= 1'b0; r2_ch <= '0;
      r2_pp <= '0; r2_pi <= '0; r2_pd <= '0;
      r3_v <= 1'b0; r3_ic <= 1'b0; r3_ch <= '0; r3_y <= '0;
      out_valid <= 1'b0; out_ch <= '0; mv <= '0;
      out_sat <= 1'b0; out_iclamp <= 1'b0;
    end else begin
      r1_v <= in_ok;
      if (in_ok) begin
        r1_ch <= in_ch; r1_ic <= ic_c;
        r1_e  <= e_c;   r1_de <= de_c; r1_ni <= ni_c;
        r1_kp <= g_kp;  r1_ki <= g_ki; r1_kd <= g_kd;
      end
      r2_v <= r1_v;
      if (r1_v) begin
        r2_ch <= r1_ch; r2_ic <= r1_ic;
        r2_pp <= pp_c;  r2_pi <= pi_c; r2_pd <= pd_c;
      end
      r3_v <= r2_v;
      if (r2_v) begin
        r3_ch <= r2_ch; r3_ic <= r2_ic;
        r3_y  <= acc_c >>> FRAC;
      end
      out_valid <= r3_v;
      if (r3_v) begin
        out_ch     <= r3_ch;
        out_iclamp <= r3_ic;
        mv         <= sat64[W-1:0];
        out_sat    <= (sat64 != y64);
      end
    end
  end

endmodule
